mem_request_unit: RTL and testbench
===================================

Name: mem_request_unit

Overview:
- Sits between cpu_core and the memory bus.
- Accepts instruction-fetch and data load/store requests from the core and serialises them onto a single memory port (data before fetch).
- Returns fetched instructions and load data with one-cycle valid strobes, and raises stall while work is outstanding.
- Aborts stuck transactions after a bounded wait.

Parameters:
TIMEOUT_CYCLES, 255, max WAIT cycles with mem_busy high before abort (1..65535)
ERR_DATA, 32'hDEAD_BEEF, value returned on instr_out/data_out when a transaction times out

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
i_fetch_req  in  1  one-cycle pulse: fetch instruction at i_fetch_addr
i_fetch_addr  in  32  fetch address (PC)
d_read_req  in  1  one-cycle pulse: load from d_addr
d_write_req  in  1  one-cycle pulse: store d_wdata to d_addr
d_addr  in  32  data address
d_wdata  in  32  store data
d_sel  in  4  byte enables for load/store
instr_out  out  32  last fetched instruction (held)
instr_valid  out  1  one-cycle pulse: instr_out updated
data_out  out  32  last load data (held)
data_valid  out  1  one-cycle pulse: data_out updated (loads only)
stall  out  1  high while any request is pending or in flight
err  out  1  one-cycle pulse: completing transaction timed out
mem_addr  out  32  bus address
mem_wdata  out  32  bus write data
mem_sel  out  4  bus byte enables (4'hF for fetch)
mem_read  out  1  one-cycle read strobe
mem_write  out  1  one-cycle write strobe
mem_busy  in  1  memory busy; low in WAIT = transaction complete
mem_rdata  in  32  read data, valid in WAIT cycle where mem_busy==0

Behaviour:
- Reset:
  - state=IDLE; pending flags, wait counter and all outputs cleared to 0.
  - Reset mid-transaction abandons it with no valid/err pulse.
- Capture:
  - Request pulses are latched into pending_fetch / pending_data (address, wdata, sel, type) at the edge ending their cycle.
  - A new request of a type already pending or in flight is ignored.
  - d_read_req and d_write_req together: treated as write; read dropped.
- stall is combinational from registers: (state != IDLE) | pending_fetch | pending_data.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE -> REQ when any pending flag is set. Data is selected over fetch.
  - REQ (1 cycle):
    - mem_addr, mem_sel and mem_wdata driven from the selected latch.
    - mem_read or mem_write = 1 for this cycle only.
    - Next state: WAIT, with counter=0.
  - WAIT:
    - mem_busy==0: capture mem_rdata (reads), go to DONE.
    - mem_busy==1: counter++. When counter reaches TIMEOUT_CYCLES, go to DONE with the timeout flag set.
  - DONE (1 cycle):
    - Fetch: instr_out updated, instr_valid=1.
    - Load: data_out updated, data_valid=1.
    - Store: no valid pulse.
    - Timeout: ERR_DATA substituted for the read value, err=1.
    - The served pending flag clears.
    - Next state: REQ if the other flag is still pending, else IDLE.
- Latency:
  - Request at cycle C: strobe at C+1, WAIT from C+2.
  - Zero-wait memory gives the valid pulse at C+3.
- Outside REQ: mem_read=mem_write=0. mem_addr/mem_wdata/mem_sel hold their last values.
- Simultaneous fetch and data request in the same cycle: data transaction completes first, then the fetch is strobed in the cycle after data DONE.
- A request arriving in the same cycle as DONE of the other type is captured normally.
- Counter is 16 bits. mem_busy falling in the same cycle the counter hits the limit counts as success, not timeout.

Test Plan:
- Reset then fetch: i_fetch_req at C with addr 0x0000_0004, memory zero-wait returns 0x0082_2083 -> mem_read=1, mem_addr=0x4 at C+1; instr_valid=1, instr_out=0x0082_2083 at C+3; stall low at C+4.
- Load with 3 busy cycles: d_read_req, addr 0x100, sel 4'hF, rdata 0x1234_5678 -> data_valid at C+6, data_out=0x1234_5678, err=0.
- Store: d_write_req, addr 0x200, wdata 0xCAFE_F00D, sel 4'b0011 -> mem_write pulse at C+1 with those values; no data_valid; stall low after DONE.
- Simultaneous i_fetch_req (0x8) and d_read_req (0x300) -> first strobe addr 0x300, data_valid first; second strobe addr 0x8, instr_valid after; stall high throughout.
- Timeout with TIMEOUT_CYCLES=4 and mem_busy held high -> err=1, instr_out=0xDEAD_BEEF, instr_valid=1, FSM returns to IDLE.
- rst asserted during WAIT -> next cycle all outputs 0, stall=0; a subsequent fetch completes normally.

Source files
------------

// File: rtl/mem_request_unit.sv
// mem_request_unit: serialises core fetch/load/store pulses onto one memory port (data first), returns read results with valid strobes, stall while busy, err on timeout
module mem_request_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch_req,
  input  logic [31:0] i_fetch_addr,
  input  logic        d_read_req,
  input  logic        d_write_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        stall,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_busy,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);
  state_t state, state_nxt;
  logic pend_f, pend_d, d_wr, cur_d, timed_out;
  logic [31:0] f_addr, d_addr_q, d_wdata_q;
  logic [3:0] d_sel_q;
  logic [15:0] cnt;
  logic cap_f, cap_d, pf_nxt, pd_nxt, wr_nxt, go_req, wait_done;
  logic [31:0] fa_nxt, da_nxt, dw_nxt;
  logic [3:0] ds_nxt;
  always_comb begin
    cap_f = i_fetch_req & ~pend_f;
    cap_d = (d_read_req | d_write_req) & ~pend_d;
    pf_nxt = (pend_f & ~(state == DONE & ~cur_d)) | cap_f;
    pd_nxt = (pend_d & ~(state == DONE & cur_d)) | cap_d;
    fa_nxt = cap_f ? i_fetch_addr : f_addr;
    da_nxt = cap_d ? d_addr : d_addr_q;
    dw_nxt = cap_d ? d_wdata : d_wdata_q;
    ds_nxt = cap_d ? d_sel : d_sel_q;
    wr_nxt = cap_d ? d_write_req : d_wr;
    go_req = (state == IDLE | state == DONE) & (pf_nxt | pd_nxt);
    wait_done = state == WAIT & (~mem_busy | cnt == LIMIT);
    state_nxt = state == REQ ? WAIT :
                state == WAIT ? (wait_done ? DONE : WAIT) :
                go_req ? REQ : IDLE;
    instr_valid = state == DONE & ~cur_d;
    data_valid = state == DONE & cur_d & ~d_wr;
    err = state == DONE & timed_out;
    stall = state != IDLE | pend_f | pend_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend_f <= 1'b0;
      pend_d <= 1'b0;
      d_wr <= 1'b0;
      cur_d <= 1'b0;
      timed_out <= 1'b0;
      f_addr <= '0;
      d_addr_q <= '0;
      d_wdata_q <= '0;
      d_sel_q <= '0;
      cnt <= '0;
      instr_out <= '0;
      data_out <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_sel <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      state <= state_nxt;
      pend_f <= pf_nxt;
      pend_d <= pd_nxt;
      f_addr <= fa_nxt;
      d_addr_q <= da_nxt;
      d_wdata_q <= dw_nxt;
      d_sel_q <= ds_nxt;
      d_wr <= wr_nxt;
      mem_read <= go_req & ~(pd_nxt & wr_nxt);
      mem_write <= go_req & pd_nxt & wr_nxt;
      cnt <= (state == WAIT & mem_busy) ? cnt + 16'd1 : 16'd0;
      if (go_req) begin
        cur_d <= pd_nxt;
        mem_addr <= pd_nxt ? da_nxt : fa_nxt;
        mem_sel <= pd_nxt ? ds_nxt : 4'hF;
        mem_wdata <= pd_nxt ? dw_nxt : mem_wdata;
      end
      if (wait_done) begin
        timed_out <= mem_busy;
        if (!cur_d) instr_out <= mem_busy ? ERR_DATA : mem_rdata;
        else if (!d_wr) data_out <= mem_busy ? ERR_DATA : mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit: table-driven and scoreboard checks of mem_request_unit with a small memory model
module tb_mem_request_unit;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic rst, i_fetch_req, d_read_req, d_write_req;
  logic [31:0] i_fetch_addr, d_addr, d_wdata;
  logic [3:0] d_sel;
  logic [31:0] instr_out, data_out, mem_addr, mem_wdata, mem_rdata;
  logic instr_valid, data_valid, stall, err, mem_read, mem_write, mem_busy;
  logic [3:0] mem_sel;
  logic [31:0] mem_model [logic [31:0]];
  int busy_n = 0;
  int busy_left = 0;
  logic [31:0] rdata_r = '0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic f, r, w;
    logic [31:0] addr, wdata, rdata;
    logic [3:0] sel;
    int busy, cyc;
    logic e;
    logic [31:0] val;
  } vec_t;
  typedef struct {
    int kind;
    logic [31:0] val;
    logic e;
  } sb_t;
  sb_t sb[$];

  mem_request_unit #(.TIMEOUT_CYCLES(4), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst), .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
    .d_read_req(d_read_req), .d_write_req(d_write_req), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_sel(d_sel), .instr_out(instr_out), .instr_valid(instr_valid),
    .data_out(data_out), .data_valid(data_valid), .stall(stall), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_read(mem_read),
    .mem_write(mem_write), .mem_busy(mem_busy), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_busy = busy_left != 0;
  assign mem_rdata = rdata_r;

  always @(negedge clk)
    if (mem_read || mem_write) begin
      busy_left <= busy_n + 1;
      rdata_r <= mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
    end else if (busy_left != 0) busy_left <= busy_left - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (instr_valid || data_valid || err) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse iv=%b dv=%b err=%b exp=none at %0t", instr_valid, data_valid, err, $time);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("instr_valid", 32'(instr_valid), 32'(e.kind == 0));
        check("data_valid", 32'(data_valid), 32'(e.kind == 1));
        check("err", 32'(err), 32'(e.e));
        if (e.kind == 0) check("instr_out", instr_out, e.val);
        if (e.kind == 1) check("data_out", data_out, e.val);
      end
    end

  task automatic clear_req();
    i_fetch_req = 1'b0;
    d_read_req = 1'b0;
    d_write_req = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int kind;
    mem_model[v.addr] = v.rdata;
    busy_n = v.busy;
    kind = v.w ? 2 : v.f ? 0 : 1;
    @(negedge clk);
    i_fetch_req = v.f;
    d_read_req = v.r;
    d_write_req = v.w;
    i_fetch_addr = v.addr;
    d_addr = v.addr;
    d_wdata = v.wdata;
    d_sel = v.sel;
    if (kind < 2 || v.e) sb.push_back('{kind, v.val, v.e});
    @(negedge clk);
    clear_req();
    check("mem_read", 32'(mem_read), 32'(!v.w));
    check("mem_write", 32'(mem_write), 32'(v.w));
    check("mem_addr", mem_addr, v.addr);
    check("mem_sel", 32'(mem_sel), 32'(v.f ? 4'hF : v.sel));
    if (v.w) check("mem_wdata", mem_wdata, v.wdata);
    wait_idle(n);
    check("stall_cycles", 32'(n), 32'(v.cyc));
  endtask

  vec_t vecs[9];
  int n;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h4,   32'h0,         32'h0082_2083, 4'h0,    0,   3, 1'b0, 32'h0082_2083};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h0,         32'h1234_5678, 4'hF,    3,   6, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h200, 32'hCAFE_F00D, 32'h0,         4'b0011, 0,   3, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h10,  32'h0,         32'h7777_0010, 4'h0,    100, 7, 1'b1, ERR};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h104, 32'h0,         32'hA5A5_0001, 4'b0110, 4,   7, 1'b0, 32'hA5A5_0001};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h108, 32'h0,         32'hA5A5_0002, 4'hF,    5,   7, 1'b1, ERR};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h20C, 32'h1122_3344, 32'h0,         4'b1100, 1,   4, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 32'h210, 32'h5555_AAAA, 32'h0,         4'hF,    9,   7, 1'b1, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h14,  32'h0,         32'h0000_0013, 4'h0,    2,   5, 1'b0, 32'h0000_0013};
    rst = 1'b1;
    clear_req();
    i_fetch_addr = '0;
    d_addr = '0;
    d_wdata = '0;
    d_sel = '0;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_instr_out", instr_out, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    rst = 1'b0;
    foreach (vecs[i]) run_vec(vecs[i]);

    mem_model[32'h8] = 32'h1111_1111;
    mem_model[32'h300] = 32'h3333_3333;
    busy_n = 0;
    sb.push_back('{1, 32'h3333_3333, 1'b0});
    sb.push_back('{0, 32'h1111_1111, 1'b0});
    @(negedge clk);
    i_fetch_req = 1'b1;
    i_fetch_addr = 32'h8;
    d_read_req = 1'b1;
    d_addr = 32'h300;
    @(negedge clk);
    clear_req();
    check("sim_first_read", 32'(mem_read), 32'h1);
    check("sim_first_addr", mem_addr, 32'h300);
    n = 0;
    while (stall && n < 100) begin
      n++;
      if (n == 4) begin
        check("sim_second_read", 32'(mem_read), 32'h1);
        check("sim_second_addr", mem_addr, 32'h8);
      end
      @(negedge clk);
    end
    check("sim_stall_cycles", 32'(n), 32'd6);

    mem_model[32'h400] = 32'h0000_0044;
    mem_model[32'h20] = 32'h2020_2020;
    sb.push_back('{1, 32'h0000_0044, 1'b0});
    sb.push_back('{0, 32'h2020_2020, 1'b0});
    @(negedge clk);
    d_read_req = 1'b1;
    d_addr = 32'h400;
    @(negedge clk);
    clear_req();
    repeat (2) @(negedge clk);
    check("done_cap_dv", 32'(data_valid), 32'h1);
    i_fetch_req = 1'b1;
    i_fetch_addr = 32'h20;
    @(negedge clk);
    clear_req();
    check("done_cap_read", 32'(mem_read), 32'h1);
    check("done_cap_addr", mem_addr, 32'h20);
    wait_idle(n);
    check("done_cap_cycles", 32'(n), 32'd3);

    mem_model[32'h30] = 32'h0000_3030;
    mem_model[32'h34] = 32'hBAD0_0034;
    sb.push_back('{0, 32'h0000_3030, 1'b0});
    @(negedge clk);
    i_fetch_req = 1'b1;
    i_fetch_addr = 32'h30;
    @(negedge clk);
    i_fetch_addr = 32'h34;
    @(negedge clk);
    clear_req();
    wait_idle(n);
    check("dup_cycles", 32'(n), 32'd2);
    check("dup_addr", mem_addr, 32'h30);

    busy_n = 50;
    mem_model[32'h40] = 32'h4040_4040;
    sb.push_back('{0, 32'h4040_4040, 1'b0});
    @(negedge clk);
    i_fetch_req = 1'b1;
    i_fetch_addr = 32'h40;
    @(negedge clk);
    clear_req();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    check("wrst_stall", 32'(stall), 32'h0);
    check("wrst_instr_out", instr_out, 32'h0);
    check("wrst_data_out", data_out, 32'h0);
    check("wrst_mem_addr", mem_addr, 32'h0);
    check("wrst_mem_sel", 32'(mem_sel), 32'h0);
    check("wrst_err", 32'(err), 32'h0);
    rst = 1'b0;
    run_vec('{1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0000_4444, 4'h0, 1, 4, 1'b0, 32'h0000_4444});
    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
